cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 22 ++
 rtl/ctrl_word_counter.sv | 37 +++
 rtl/cpu_run_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the CPU run controller.
// The sequence states and the load-target encoding live here.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_OUT,
        DONE
    } state_t;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    function automatic logic [31:0] byte_addr(input logic [31:0] idx, input logic [31:0] step);
        return idx * step;
    endfunction

endpackage

// File: rtl/ctrl_word_counter.sv
// Loadable up/down counter with a terminal-value compare flag.
// Priority: reset, clear, load, increment, decrement.
module ctrl_word_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_term
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + W'(1);
        end else if (i_dec) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == i_term);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Load / run / dump sequencer between the host test interface and the CPU top.
// Holds the CPU in reset while loading, runs it for a fixed cycle count, then streams data memory out.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] max_cycles,
    input  logic [10:0] dump_words,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_target,
    input  logic        ld_last,
    input  logic [31:0] ld_data,
    output logic        cpu_arst_n,
    output logic        cpu_enable,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        dump_valid,
    output logic        dump_last,
    output logic [31:0] dump_data,
    input  logic        dump_ready,
    output logic        busy,
    output logic        done,
    output logic        load_err
);

    localparam int unsigned IW = $clog2(IMEM_WORDS + 1);
    localparam int unsigned DW = $clog2(DMEM_WORDS + 1);
    localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    state_t r_state, w_next;

    logic [IW-1:0] w_icnt;
    logic [DW-1:0] w_dcnt;
    logic [31:0]   w_run_cnt;
    logic [10:0]   w_dump_idx;
    logic          w_imem_full, w_dmem_full, w_run_last, w_dump_last;
    logic [10:0]   r_dump_n, w_dump_clamped;
    logic [LW-1:0] r_wait;
    logic [31:0]   r_dump_data;
    logic          r_load_err;

    logic w_start_ok, w_hs, w_iwr, w_dwr, w_full_hit, w_wait_end, w_dump_adv;

    assign w_start_ok     = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_hs           = (r_state == LOAD) && ld_valid;
    assign w_iwr          = w_hs && (ld_target == TGT_IMEM) && !w_imem_full;
    assign w_dwr          = w_hs && (ld_target == TGT_DMEM) && !w_dmem_full;
    assign w_full_hit     = w_hs && ((ld_target == TGT_IMEM) ? w_imem_full : w_dmem_full);
    assign w_wait_end     = (r_state == DUMP_WAIT) && (r_wait == LW'(RD_LAT - 1));
    assign w_dump_adv     = (r_state == DUMP_OUT) && dump_ready && !w_dump_last;
    assign w_dump_clamped = (32'(dump_words) > DMEM_WORDS) ? 11'(DMEM_WORDS) : dump_words;

    ctrl_word_counter #(.W(IW)) u_imem_cnt (
        .i_clk(clk), .i_rst(rst), .i_clr(w_start_ok), .i_load(1'b0), .i_load_val('0),
        .i_inc(w_iwr), .i_dec(1'b0), .i_term(IW'(IMEM_WORDS)),
        .o_count(w_icnt), .o_term(w_imem_full)
    );

    ctrl_word_counter #(.W(DW)) u_dmem_cnt (
        .i_clk(clk), .i_rst(rst), .i_clr(w_start_ok), .i_load(1'b0), .i_load_val('0),
        .i_inc(w_dwr), .i_dec(1'b0), .i_term(DW'(DMEM_WORDS)),
        .o_count(w_dcnt), .o_term(w_dmem_full)
    );

    ctrl_word_counter #(.W(32)) u_run_cnt (
        .i_clk(clk), .i_rst(rst), .i_clr(1'b0), .i_load(w_start_ok), .i_load_val(max_cycles),
        .i_inc(1'b0), .i_dec(r_state == RUN), .i_term(32'd1),
        .o_count(w_run_cnt), .o_term(w_run_last)
    );

    ctrl_word_counter #(.W(11)) u_dump_cnt (
        .i_clk(clk), .i_rst(rst), .i_clr(w_start_ok), .i_load(1'b0), .i_load_val('0),
        .i_inc(w_dump_adv), .i_dec(1'b0), .i_term(r_dump_n - 11'd1),
        .o_count(w_dump_idx), .o_term(w_dump_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dump_n    <= '0;
            r_load_err  <= 1'b0;
            r_wait      <= '0;
            r_dump_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_dump_n   <= w_dump_clamped;
                r_load_err <= 1'b0;
            end else if (w_full_hit) begin
                r_load_err <= 1'b1;
            end
            if (r_state == DUMP_RD) begin
                r_wait <= '0;
            end else if (r_state == DUMP_WAIT) begin
                r_wait <= r_wait + LW'(1);
            end
            if (w_wait_end) begin
                r_dump_data <= rdata_ext_2;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        ld_ready    = 1'b0;
        cpu_arst_n  = 1'b0;
        cpu_enable  = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        dump_valid  = 1'b0;
        dump_last   = 1'b0;
        dump_data   = r_dump_data;
        busy        = 1'b0;
        done        = 1'b0;
        load_err    = r_load_err;

        case (r_state)
            IDLE: begin
                if (start) w_next = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b1;
                if (w_iwr) begin
                    wen_ext   = 1'b1;
                    addr_ext  = byte_addr(32'(w_icnt), 32'(ADDR_STEP));
                    wdata_ext = ld_data;
                end
                if (w_dwr) begin
                    wen_ext_2   = 1'b1;
                    addr_ext_2  = byte_addr(32'(w_dcnt), 32'(ADDR_STEP));
                    wdata_ext_2 = ld_data;
                end
                // a zero run length skips RUN; a zero dump length skips the dump
                if (ld_valid && ld_last) begin
                    if (w_run_cnt != '0)      w_next = RUN;
                    else if (r_dump_n != '0)  w_next = DUMP_RD;
                    else                      w_next = DONE;
                end
            end
            RUN: begin
                cpu_arst_n = 1'b1;
                cpu_enable = 1'b1;
                busy       = 1'b1;
                if (w_run_last) w_next = (r_dump_n != '0) ? DUMP_RD : DONE;
            end
            DUMP_RD: begin
                cpu_arst_n = 1'b1;
                busy       = 1'b1;
                ren_ext_2  = 1'b1;
                addr_ext_2 = byte_addr(32'(w_dump_idx), 32'(ADDR_STEP));
                w_next     = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                cpu_arst_n = 1'b1;
                busy       = 1'b1;
                if (w_wait_end) w_next = DUMP_OUT;
            end
            DUMP_OUT: begin
                cpu_arst_n = 1'b1;
                busy       = 1'b1;
                dump_valid = 1'b1;
                dump_last  = w_dump_last;
                if (dump_ready) w_next = w_dump_last ? DONE : DUMP_RD;
            end
            DONE: begin
                cpu_arst_n = 1'b1;
                done       = 1'b1;
                if (start) w_next = LOAD;
            end
            default: w_next = IDLE;
        endcase

        // nothing reaches the memories or the CPU while reset is asserted
        if (rst) begin
            ld_ready    = 1'b0;
            cpu_arst_n  = 1'b0;
            cpu_enable  = 1'b0;
            addr_ext    = '0;
            wen_ext     = 1'b0;
            wdata_ext   = '0;
            addr_ext_2  = '0;
            wen_ext_2   = 1'b0;
            ren_ext_2   = 1'b0;
            wdata_ext_2 = '0;
            dump_valid  = 1'b0;
            dump_last   = 1'b0;
            dump_data   = '0;
            busy        = 1'b0;
            done        = 1'b0;
            load_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized sequences against a
// sequence-level model of load / run / dump, with a responding data memory.
module tb_cpu_run_ctrl;

    localparam int unsigned IMEM = 8;
    localparam int unsigned DMEM = 16;
    localparam int unsigned LAT  = 2;
    localparam int unsigned STEP = 4;

    logic        clk, rst, start, ld_valid, ld_ready, ld_target, ld_last;
    logic [31:0] max_cycles, ld_data;
    logic [10:0] dump_words;
    logic        cpu_arst_n, cpu_enable, wen_ext, wen_ext_2, ren_ext_2;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        dump_valid, dump_last, dump_ready, busy, done, load_err;
    logic [31:0] dump_data;

    cpu_run_ctrl #(.ADDR_STEP(STEP), .IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .max_cycles(max_cycles), .dump_words(dump_words),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_target(ld_target), .ld_last(ld_last),
        .ld_data(ld_data), .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .dump_valid(dump_valid), .dump_last(dump_last), .dump_data(dump_data),
        .dump_ready(dump_ready), .busy(busy), .done(done), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mism = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mism++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- data memory responder ----------------
    logic [31:0] env_mem [DMEM];
    bit   [DMEM-1:0] env_wr = '0;
    logic [31:0] pipe [LAT];

    function automatic logic [31:0] env_word(input logic [3:0] i);
        return env_wr[i] ? env_mem[i] : (32'hD000_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (wen_ext_2) begin
            env_mem[addr_ext_2[5:2]] <= wdata_ext_2;
            env_wr[addr_ext_2[5:2]]  <= 1'b1;
        end
        pipe[0] <= ren_ext_2 ? env_word(addr_ext_2[5:2]) : $urandom;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata_ext_2 = pipe[LAT-1];

    // ---------------- dump_ready driver ----------------
    int hold_left = 0;
    bit rdy_rand  = 1'b0;
    initial begin
        dump_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (dump_valid && hold_left > 0) begin
                dump_ready = 1'b0;
                hold_left--;
            end else begin
                dump_ready = rdy_rand ? 1'($urandom) : 1'b1;
            end
        end
    end

    // ---------------- activity monitor for literal checks ----------------
    int n_en = 0, n_wen = 0, n_wen2 = 0, n_ren2 = 0, n_dv = 0, n_last = 0;
    logic [31:0] dq[$];
    logic [31:0] wa[$];
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            n_en   += int'(cpu_enable);
            n_wen  += int'(wen_ext);
            n_wen2 += int'(wen_ext_2);
            n_ren2 += int'(ren_ext_2);
            n_dv   += int'(dump_valid);
            if (wen_ext) wa.push_back(addr_ext);
            if (dump_valid && dump_ready) begin
                dq.push_back(dump_data);
                n_last += int'(dump_last);
            end
        end
    end

    // ---------------- sequence-level reference model ----------------
    typedef struct {
        logic ldr, arst, en, wen, wen2, ren2, dv, dl, busy, done, lerr;
        logic [31:0] a1, d1, a2, d2, dd;
    } exp_t;

    logic [31:0] m_mem [DMEM];
    bit   [DMEM-1:0] m_wr = '0;

    function automatic logic [31:0] m_word(input int unsigned i);
        return m_wr[i] ? m_mem[i] : (32'hD000_0000 | i);
    endfunction

    task automatic cmp_all(input exp_t e, input bit full);
        chk("ld_ready", 32'(ld_ready), 32'(e.ldr));
        chk("cpu_arst_n", 32'(cpu_arst_n), 32'(e.arst));
        chk("cpu_enable", 32'(cpu_enable), 32'(e.en));
        chk("wen_ext", 32'(wen_ext), 32'(e.wen));
        chk("wen_ext_2", 32'(wen_ext_2), 32'(e.wen2));
        chk("ren_ext_2", 32'(ren_ext_2), 32'(e.ren2));
        chk("dump_valid", 32'(dump_valid), 32'(e.dv));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("load_err", 32'(load_err), 32'(e.lerr));
        if (full || e.wen) begin
            chk("addr_ext", addr_ext, e.a1);
            chk("wdata_ext", wdata_ext, e.d1);
        end
        if (full || e.wen2) begin
            chk("addr_ext_2", addr_ext_2, e.a2);
            chk("wdata_ext_2", wdata_ext_2, e.d2);
        end else if (e.ren2) begin
            chk("addr_ext_2_rd", addr_ext_2, e.a2);
        end
        if (full || e.dv) begin
            chk("dump_data", dump_data, e.dd);
            chk("dump_last", 32'(dump_last), 32'(e.dl));
        end
    endtask

    task automatic step(output bit ab);
        exp_t z;
        z = '{default: '0};
        @(negedge clk);
        ab = rst;
        if (rst) cmp_all(z, 1'b1);
    endtask

    initial begin : model
        exp_t e;
        bit was_done, lerr_m, ab, go, fin, acc;
        int unsigned mc, dw, ni, nd;
        was_done = 0;
        lerr_m   = 0;
        forever begin
            go = 0;
            while (!go) begin
                step(ab);
                if (ab) begin
                    was_done = 0;
                    lerr_m   = 0;
                end else begin
                    e = '{default: '0};
                    e.arst = was_done; e.done = was_done; e.lerr = lerr_m;
                    cmp_all(e, 1'b0);
                    if (start) begin
                        go = 1;
                        mc = max_cycles;
                        dw = (int'(dump_words) > DMEM) ? DMEM : int'(dump_words);
                    end
                end
            end
            lerr_m = 0; ni = 0; nd = 0; ab = 0; fin = 0;
            while (!ab && !fin) begin
                step(ab);
                if (!ab) begin
                    e = '{default: '0};
                    e.ldr = 1; e.busy = 1; e.lerr = lerr_m;
                    if (ld_valid) begin
                        if (ld_target == 1'b0) begin
                            if (ni < IMEM) begin
                                e.wen = 1; e.a1 = ni * STEP; e.d1 = ld_data; ni++;
                            end else lerr_m = 1;
                        end else begin
                            if (nd < DMEM) begin
                                e.wen2 = 1; e.a2 = nd * STEP; e.d2 = ld_data;
                                m_mem[nd] = ld_data; m_wr[nd] = 1'b1; nd++;
                            end else lerr_m = 1;
                        end
                        fin = ld_last;
                    end
                    cmp_all(e, 1'b0);
                end
            end
            for (int unsigned k = 0; k < mc && !ab; k++) begin
                step(ab);
                if (!ab) begin
                    e = '{default: '0};
                    e.arst = 1; e.en = 1; e.busy = 1; e.lerr = lerr_m;
                    cmp_all(e, 1'b0);
                end
            end
            for (int unsigned i = 0; i < dw && !ab; i++) begin
                step(ab);
                if (!ab) begin
                    e = '{default: '0};
                    e.arst = 1; e.busy = 1; e.ren2 = 1; e.a2 = i * STEP; e.lerr = lerr_m;
                    cmp_all(e, 1'b0);
                end
                for (int unsigned w = 0; w < LAT && !ab; w++) begin
                    step(ab);
                    if (!ab) begin
                        e = '{default: '0};
                        e.arst = 1; e.busy = 1; e.lerr = lerr_m;
                        cmp_all(e, 1'b0);
                    end
                end
                acc = 0;
                while (!ab && !acc) begin
                    step(ab);
                    if (!ab) begin
                        e = '{default: '0};
                        e.arst = 1; e.busy = 1; e.dv = 1; e.dl = (i == dw - 1);
                        e.dd = m_word(i); e.lerr = lerr_m;
                        cmp_all(e, 1'b0);
                        acc = dump_ready;
                    end
                end
            end
            was_done = !ab;
            if (ab) lerr_m = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [31:0] mc, input logic [10:0] dw);
        max_cycles = mc;
        dump_words = dw;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic tgt, input logic last, input logic [31:0] d,
                        input int unsigned gap, input bit noisy);
        bit got;
        for (int unsigned g = 0; g < gap; g++) begin
            ld_valid = 1'b0; ld_target = 1'($urandom); ld_last = 1'($urandom); ld_data = $urandom;
            start = noisy ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        ld_valid = 1'b1; ld_target = tgt; ld_last = last; ld_data = d;
        start = noisy ? 1'($urandom) : 1'b0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = ld_ready;
            @(posedge clk); #1;
        end
        chk("ld_handshake", 32'(got), 32'd1);
        ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        chk(name, 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : driver
        int en0, wen0, wen20, ren20, dv0, last0, dq0, wa0;
        bit seen;
        rst = 1'b1; start = 1'b0; max_cycles = '0; dump_words = '0;
        ld_valid = 1'b0; ld_target = 1'b0; ld_last = 1'b0; ld_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // basic: 3 imem + 2 dmem words, 10 run cycles, 2 dump words
        en0 = n_en; wen0 = n_wen; wen20 = n_wen2; ren20 = n_ren2; last0 = n_last;
        dq0 = dq.size(); wa0 = wa.size();
        do_start(32'd10, 11'd2);
        send(1'b0, 1'b0, 32'hA000_0000, 0, 0);
        send(1'b0, 1'b0, 32'hA000_0001, 0, 0);
        send(1'b0, 1'b0, 32'hA000_0002, 0, 0);
        send(1'b1, 1'b0, 32'hB000_0000, 0, 0);
        send(1'b1, 1'b1, 32'hB000_0001, 0, 0);
        wait_done("basic_done");
        chk("basic_en_cycles", 32'(n_en - en0), 32'd10);
        chk("basic_imem_writes", 32'(n_wen - wen0), 32'd3);
        chk("basic_dmem_writes", 32'(n_wen2 - wen20), 32'd2);
        chk("basic_reads", 32'(n_ren2 - ren20), 32'd2);
        chk("basic_last_cnt", 32'(n_last - last0), 32'd1);
        chk("basic_imem_addr2", wa[wa0 + 2], 32'd8);
        chk("basic_dump0", dq[dq0], 32'hB000_0000);
        chk("basic_dump1", dq[dq0 + 1], 32'hB000_0001);

        // ld_valid every other cycle
        wen0 = n_wen; wa0 = wa.size();
        do_start(32'd3, 11'd2);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 32'h1100_0000 + 32'(i), 1, 0);
        send(1'b1, 1'b0, 32'h2200_0000, 1, 0);
        send(1'b1, 1'b1, 32'h2200_0001, 1, 0);
        wait_done("gap_done");
        chk("gap_imem_writes", 32'(n_wen - wen0), 32'd4);
        chk("gap_imem_addr3", wa[wa0 + 3], 32'd12);

        // imem overflow: 10 words into an 8-word memory
        wen0 = n_wen; dq0 = dq.size();
        do_start(32'd2, 11'd1);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 32'h3300_0000 + 32'(i), 0, 0);
        send(1'b1, 1'b1, 32'h4400_0000, 0, 0);
        wait_done("ovf_done");
        chk("ovf_imem_writes", 32'(n_wen - wen0), 32'd8);
        chk("ovf_load_err", 32'(load_err), 32'd1);
        chk("ovf_dump0", dq[dq0], 32'h4400_0000);

        // zero run length and zero dump length
        en0 = n_en; dv0 = n_dv;
        do_start(32'd0, 11'd0);
        send(1'b0, 1'b1, 32'h5500_0000, 0, 0);
        wait_done("zero_done");
        chk("zero_en_cycles", 32'(n_en - en0), 32'd0);
        chk("zero_dump_valid", 32'(n_dv - dv0), 32'd0);

        // dump_ready held low 5 cycles on word 0
        ren20 = n_ren2; dv0 = n_dv; dq0 = dq.size();
        hold_left = 5;
        do_start(32'd1, 11'd3);
        send(1'b1, 1'b0, 32'hC000_0000, 0, 0);
        send(1'b1, 1'b0, 32'hC000_0001, 0, 0);
        send(1'b1, 1'b1, 32'hC000_0002, 0, 0);
        wait_done("hold_done");
        chk("hold_reads", 32'(n_ren2 - ren20), 32'd3);
        chk("hold_valid_cycles", 32'(n_dv - dv0), 32'd8);
        chk("hold_dump0", dq[dq0], 32'hC000_0000);

        // reset during RUN cycle 4, then a clean restart
        en0 = n_en;
        do_start(32'd20, 11'd2);
        send(1'b0, 1'b0, 32'h6600_0000, 0, 0);
        send(1'b1, 1'b1, 32'h6600_0001, 0, 0);
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = (n_en - en0 >= 3);
        end
        chk("rst_run_reached", 32'(seen), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_en_cycles", 32'(n_en - en0), 32'd3);
        @(posedge clk); #1;
        wen0 = n_wen; wa0 = wa.size(); dq0 = dq.size();
        do_start(32'd2, 11'd1);
        send(1'b0, 1'b0, 32'h7700_0000, 0, 0);
        send(1'b1, 1'b1, 32'h5EED_0001, 0, 0);
        wait_done("restart_done");
        chk("restart_imem_addr0", wa[wa0], 32'd0);
        chk("restart_dump0", dq[dq0], 32'h5EED_0001);

        // randomized sequences; first one also exercises the dump length clamp
        rdy_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            int unsigned nw;
            dq0 = dq.size();
            nw = $urandom_range(1, 12);
            do_start(32'($urandom_range(0, 15)), (it == 0) ? 11'd20 : 11'($urandom_range(0, 18)));
            for (int unsigned w = 0; w < nw; w++)
                send(1'($urandom), w == nw - 1, $urandom, $urandom_range(0, 2), 1);
            wait_done("rand_done");
            if (it == 0) chk("clamp_dump_words", 32'(dq.size() - dq0), 32'd16);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
